// File: rtl/soc_mem_pkg.sv
// Shared helpers for the SoC RAM: byte-offset width and port-id sizing.
// No logic and no latency; the functions are elaboration-time only.
// Backpressure: not applicable.
package soc_mem_pkg;

  // Number of byte-offset bits below the word index for a given word width.
  function automatic int align_offset(input int width);
    return $clog2(width / 8);
  endfunction

  // Width of a port identifier; a single port still needs one bit.
  function automatic int port_id_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, search starts after last winner.
// Latency: grant is combinational; last_grant updates on the edge where something wins.
// Backpressure: a requester that is not granted simply waits; no state beyond last_grant.
module rr_arbiter
  import soc_mem_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N-1:0]               i_req,
  input  logic                       i_advance,
  output logic [N-1:0]               o_grant,
  output logic [port_id_bits(N)-1:0] o_grant_idx
);

  localparam int IW = port_id_bits(N);

  logic [IW-1:0] r_last_grant;
  logic [IW-1:0] w_idx;
  logic          w_found;

  // First requester found walking upward from last_grant+1 (mod N) wins.
  // With N=1 the walk visits only port 0, so the grant is the request itself.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = r_last_grant;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(r_last_grant) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

  // Remember the winner; reset value makes port 0 the first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= IW'(N - 1);
    end else if (i_advance && w_found) begin
      r_last_grant <= o_grant_idx;
    end
  end

endmodule

// File: rtl/soc_ram_mp.sv
// Multi-port byte-addressed SoC RAM: round-robin arbitrated single-port array.
// Latency: response pulse one cycle after the accepting edge, on the granted port only.
// Backpressure: req_ready is the arbiter grant; responses cannot be stalled.
// Optional macro SOC_RAM_RANGE_CHECK_EN flags out-of-range / misaligned-write accesses.
module soc_ram_mp
  import soc_mem_pkg::*;
#(
  parameter int    DATAWIDTH      = 32,
  parameter int    ADDRWIDTH      = 12,
  parameter int    SOC_ADDR_WIDTH = 32,
  parameter int    NUM_PORTS      = 2,
  // Image name for memory-macro preload flows; the behavioural array starts undefined.
  parameter string INITFILE       = ""
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_PORTS-1:0]                      req_valid,
  output logic [NUM_PORTS-1:0]                      req_ready,
  input  logic [NUM_PORTS-1:0][SOC_ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0]                      req_we,
  input  logic [NUM_PORTS-1:0][DATAWIDTH/8-1:0]     req_be,
  input  logic [NUM_PORTS-1:0][DATAWIDTH-1:0]       req_wdata,
  output logic [NUM_PORTS-1:0]                      rsp_valid,
  output logic [NUM_PORTS-1:0][DATAWIDTH-1:0]       rsp_rdata,
  output logic [NUM_PORTS-1:0]                      rsp_err
);

  localparam int ALIGN = align_offset(DATAWIDTH);
  localparam int BEW   = DATAWIDTH / 8;
  localparam int IDW   = port_id_bits(NUM_PORTS);
  localparam int DEPTH = 1 << ADDRWIDTH;

  typedef logic [IDW-1:0] port_id_t;

  typedef struct packed {
    logic [SOC_ADDR_WIDTH-1:0] addr;
    logic                      we;
    logic [BEW-1:0]            be;
    logic [DATAWIDTH-1:0]      wdata;
  } mem_req_t;

  typedef struct packed {
    logic                 valid;
    port_id_t             id;
    logic [DATAWIDTH-1:0] rdata;
    logic                 err;
  } mem_rsp_t;

  logic [DATAWIDTH-1:0] r_mem [0:DEPTH-1];
  mem_rsp_t             r_rsp;

  logic [NUM_PORTS-1:0] w_grant;
  port_id_t             w_gidx;
  logic                 w_fire;
  mem_req_t             w_req;
  logic [ADDRWIDTH-1:0] w_widx;
  logic                 w_err;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (req_valid),
    .i_advance   (|req_valid),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );

  assign req_ready = w_grant;
  assign w_fire    = |w_grant;
  assign w_req     = '{addr:  req_addr[w_gidx],
                       we:    req_we[w_gidx],
                       be:    req_be[w_gidx],
                       wdata: req_wdata[w_gidx]};
  assign w_widx    = w_req.addr[ADDRWIDTH+ALIGN-1:ALIGN];

`ifdef SOC_RAM_RANGE_CHECK_EN
  // Anything above the array, or a write not on a word boundary, is flagged.
  assign w_err = ((w_req.addr >> (ADDRWIDTH + ALIGN)) != '0) ||
                 (w_req.we && (w_req.addr[ALIGN-1:0] != '0));
`else
  // Upper bits alias and byte-offset bits are dropped; nothing is ever flagged.
  logic w_unused_addr;
  assign w_unused_addr = ^w_req.addr;
  assign w_err         = 1'b0;
`endif

  // Byte-lane writes at the accepting edge; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (w_fire && w_req.we && !w_err) begin
      for (int b = 0; b < BEW; b++) begin
        if (w_req.be[b]) begin
          r_mem[w_widx][b*8 +: 8] <= w_req.wdata[b*8 +: 8];
        end
      end
    end
  end

  // Single response stage: reads sample the array at the accepting edge, writes return 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp <= '0;
    end else begin
      r_rsp.valid <= w_fire;
      r_rsp.id    <= w_gidx;
      r_rsp.err   <= w_fire && w_err;
      r_rsp.rdata <= (w_fire && !w_req.we && !w_err) ? r_mem[w_widx] : '0;
    end
  end

  // Steer the response to its owner; every other port sees zeros.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_rsp.valid && (r_rsp.id == IDW'(p))) begin
        rsp_valid[p] = 1'b1;
        rsp_rdata[p] = r_rsp.rdata;
        rsp_err[p]   = r_rsp.err;
      end
    end
  end

endmodule
